// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo #(
    parameter int unsigned width         = 8,
    parameter int unsigned depth         = 8,
    parameter int unsigned pointer_width = 3,
    parameter int unsigned afull_level   = 6,
    parameter int unsigned aempty_level  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [width-1:0]         data_in,
    output logic [width-1:0]         data_out,
    output logic [pointer_width:0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [pointer_width:0] DepthCount  = (pointer_width + 1)'(depth);
    localparam logic [pointer_width:0] AfullCount  = (pointer_width + 1)'(afull_level);
    localparam logic [pointer_width:0] AemptyCount = (pointer_width + 1)'(aempty_level);
    localparam logic [pointer_width:0] One         = (pointer_width + 1)'(1);

    logic [width-1:0]       mem [depth];
    logic [pointer_width:0] rd_address_q, rd_address_d;
    logic [pointer_width:0] wr_address_q, wr_address_d;
    logic [pointer_width:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   wr_en, rd_en;

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DepthCount);
    assign almost_empty = (count_q <= AemptyCount);
    assign almost_full  = (count_q >= AfullCount);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign data_out     = mem[rd_address_q[pointer_width-1:0]];

    // A write into a full FIFO is legal only when the head is popped in the
    // same cycle; a read of an empty FIFO is never bypassed from data_in.
    assign wr_en = wr && (!full || rd) && !clr;
    assign rd_en = rd && !empty && !clr;

    always_comb begin
        rd_address_d = rd_address_q;
        wr_address_d = wr_address_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (clr) begin
            rd_address_d = '0;
            wr_address_d = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
        end else begin
            if (wr_en) wr_address_d = wr_address_q + One;
            if (rd_en) rd_address_d = rd_address_q + One;
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + One;
                2'b01:   count_d = count_q - One;
                default: count_d = count_q;
            endcase
            if (wr && full && !rd) overflow_d = 1'b1;
            if (rd && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_address_q <= '0;
            wr_address_q <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rd_address_q <= rd_address_d;
            wr_address_q <= wr_address_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_address_q[pointer_width-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the FIFO's documented behaviour.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset_n = 1'b1;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic [3:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [7:0] q[$];
    bit         m_ovf = 0;
    bit         m_unf = 0;

    sync_fifo #(
        .width(8), .depth(8), .pointer_width(3), .afull_level(6), .aempty_level(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr),
        .wr           (wr),
        .rd           (rd),
        .data_in      (data_in),
        .data_out     (data_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // One clock cycle of stimulus; the model advances from the pre-edge state.
    task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
        bit m_full, m_empty, do_wr, do_rd;
        wr = w; rd = r; clr = c; data_in = d;
        @(posedge clk);
        #1;
        if (c) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            m_full  = (q.size() == 8);
            m_empty = (q.size() == 0);
            do_rd   = r && !m_empty;
            do_wr   = w && (!m_full || r);
            if (w && m_full && !r) m_ovf = 1;
            if (r && m_empty) m_unf = 1;
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(d);
        end
        wr = 0; rd = 0; clr = 0;
    endtask

    task automatic test_reset();
        clk_en = 1'b0;
        #2 reset_n = 1'b0;
        #3;
        q.delete(); m_ovf = 0; m_unf = 0;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
        #2 reset_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        logic [7:0] base;
        for (int pass = 0; pass < 2; pass++) begin
            base = (pass == 0) ? 8'h01 : 8'h11;
            for (int i = 0; i < 8; i++) begin
                cycle(1, 0, 0, base + 8'(i));
                checks++; if (count !== 4'(i + 1)) begin
                    failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
                checks++; if (almost_full !== (i + 1 >= 6)) begin
                    failures++; $display("FAIL fill_afull got=%b at count %0d", almost_full, i + 1); end
                checks++; if (full !== (i == 7)) begin
                    failures++; $display("FAIL fill_full got=%b at count %0d", full, i + 1); end
            end
            for (int i = 0; i < 8; i++) begin
                checks++; if (data_out !== base + 8'(i)) begin
                    failures++; $display("FAIL drain_data got=%h exp=%h", data_out, base + 8'(i)); end
                cycle(0, 1, 0, 8'h00);
            end
            checks++; if (empty !== 1'b1 || count !== 4'd0) begin
                failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(i + 1));
        cycle(1, 0, 0, 8'hAA);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (data_out !== 8'(i + 1)) begin
                failures++; $display("FAIL ovf_drain got=%h exp=%h", data_out, 8'(i + 1)); end
            cycle(0, 1, 0, 8'h00);
        end
        checks++; if (overflow !== 1'b1 || empty !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky got=%b/%b exp=1/1", overflow, empty); end
        cycle(0, 0, 1, 8'h00);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            cycle(1, 1, 0, d);
            checks++; if (count !== 4'd8 || full !== 1'b1) begin
                failures++; $display("FAIL simul_full_count got=%0d exp=8", count); end
            checks++; if (data_out !== q[0]) begin
                failures++; $display("FAIL simul_head got=%h exp=%h", data_out, q[0]); end
        end
        while (q.size() > 0) begin
            checks++; if (data_out !== q[0]) begin
                failures++; $display("FAIL simul_drain got=%h exp=%h", data_out, q[0]); end
            cycle(0, 1, 0, 8'h00);
        end
        cycle(1, 1, 0, 8'h5C);
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL simul_unf got=%b exp=1", underflow); end
        checks++; if (data_out !== 8'h5C) begin failures++; $display("FAIL simul_empty_data got=%h exp=5c", data_out); end
        cycle(0, 0, 1, 8'h00);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h40 + i));
        cycle(1, 0, 0, 8'hEE);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00);
        checks++; if (count !== 4'd5 || overflow !== 1'b1) begin
            failures++; $display("FAIL flush_setup got=%0d/%b exp=5/1", count, overflow); end
        cycle(1, 0, 1, 8'h77);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin
            failures++; $display("FAIL flush_count got=%0d/%b exp=0/1", count, empty); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
        cycle(1, 0, 0, 8'h33);
        checks++; if (count !== 4'd1 || data_out !== 8'h33) begin
            failures++; $display("FAIL flush_after got=%0d/%h exp=1/33", count, data_out); end
        cycle(0, 0, 1, 8'h00);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'(8'h90 + i));
        cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        wr = 1'b1; data_in = 8'hC3;
        @(posedge clk); #1;
        wr = 1'b1; data_in = 8'hC4;
        #3 reset_n = 1'b0;
        #1;
        q.delete(); m_ovf = 0; m_unf = 0;
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin
            failures++; $display("FAIL arst_count got=%0d/%b exp=0/1", count, empty); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL arst_data got=%h exp=00", data_out); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL arst_unf got=%b exp=0", underflow); end
        wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL arst_release got=%0d exp=0", count); end
    endtask

    task automatic test_random();
        logic w, r, c;
        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 2);
            cycle(w, r, c, 8'($urandom));
            checks++; if (count !== 4'(q.size())) begin
                failures++; $display("FAIL rand_count got=%0d exp=%0d", count, q.size()); end
            checks++; if (empty !== (q.size() == 0) || full !== (q.size() == 8)) begin
                failures++; $display("FAIL rand_ef got=%b%b size=%0d", empty, full, q.size()); end
            checks++; if (almost_empty !== (q.size() <= 2) || almost_full !== (q.size() >= 6)) begin
                failures++; $display("FAIL rand_almost got=%b%b size=%0d", almost_empty, almost_full, q.size()); end
            checks++; if (overflow !== m_ovf || underflow !== m_unf) begin
                failures++; $display("FAIL rand_err got=%b%b exp=%b%b", overflow, underflow, m_ovf, m_unf); end
            if (q.size() > 0) begin
                checks++; if (data_out !== q[0]) begin
                    failures++; $display("FAIL rand_data got=%h exp=%h", data_out, q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO buffer for byte and word streams between blocks sharing one clock domain. Generalises the 8x8 FIFO to arbitrary width and power-of-two depth. Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Read data is show-ahead: the head entry is always presented on data_out.

## Interface

**Parameters**
- width, 8: data word width in bits, at least 1.
- depth, 8: number of entries; a power of two, at least 2.
- pointer_width, 3: log2(depth).
- afull_level, 6: almost_full asserts when count >= afull_level; range 1..depth.
- aempty_level, 2: almost_empty asserts when count <= aempty_level; range 0..depth-1.

**Ports**
- clk, input, 1: clock. All state changes on the rising edge.
- reset_n, input, 1: reset, asynchronous, active-low.
- clr, input, 1: synchronous flush. Empties the FIFO and clears the error flags.
- wr, input, 1: write request.
- rd, input, 1: read request. Pops the head entry.
- data_in, input, width: write data.
- data_out, output, width: head entry (show-ahead, combinational from memory).
- count, output, pointer_width+1: current occupancy, 0..depth.
- empty, output, 1: count == 0.
- full, output, 1: count == depth.
- almost_empty, output, 1: count <= aempty_level.
- almost_full, output, 1: count >= afull_level.
- overflow, output, 1: sticky; set by a dropped write.
- underflow, output, 1: sticky; set by a dropped read.

## Operation

**Storage and pointers**
- Storage is depth x width.
- rd_address and wr_address are (pointer_width+1)-bit registers. The low pointer_width bits index memory; the MSB is the wrap bit.
- Both addresses increment modulo 2^(pointer_width+1). Wrap from depth-1 to 0 is natural; no special case.

**Accepted operations**
- A write is accepted when `wr && (!full || rd)`. It stores data_in at wr_pointer and increments wr_address.
- A read is accepted when `rd && !empty`. It increments rd_address.
- No write-through bypass: a read while empty is dropped even if wr is high in the same cycle.
- **Full with wr && rd:** both are accepted; count is unchanged.
- **Empty with wr && rd:** only the write is accepted; underflow sets; count becomes 1.

**Count and flags**
- count is a registered occupancy counter:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged on both or neither.
- empty, full, almost_empty and almost_full decode combinationally from count. They are glitch-free because count is a register.

**Error flags**
- overflow sets on `wr && full && !rd`.
- underflow sets on `rd && empty`.
- Both hold until clr or reset.
- A dropped operation leaves memory, pointers and count untouched.

**Flush (clr)**
- clr has priority over wr and rd in the same cycle; those requests are discarded.
- At the next edge: both addresses and count become 0, and both error flags clear.
- Memory contents are not cleared.

**Reset (reset_n low)**
- Addresses, count, overflow and underflow go to 0.
- Memory is cleared to 0.
- Asserting reset mid-operation abandons all contents immediately, regardless of clk.

## Timing

**Reset values**
- data_out = 0, count = 0, empty = 1, full = 0.
- almost_empty = 1 (since aempty_level >= 0).
- almost_full = 0.
- overflow = 0, underflow = 0.

**Latency**
- Write to data_out: 1 cycle. A write accepted at edge N into an empty FIFO appears on data_out after edge N; empty drops after the same edge.
- Read: the pop takes effect at the edge. data_out shows the next entry (or stale memory when now empty) after that edge.
- Flags and count are registered or derived from registers, so they change only at clk edges or at reset assertion.

**Handshake**
- The producer may hold wr high continuously; writes while full are dropped and flagged.
- The consumer samples data_out while rd is high. The sampled word is the one popped at that edge.

**Throughput**
- One write and one read per cycle, sustained.

## Test plan

1. **Reset:** reset_n low with clk stopped. Require count = 0, empty = 1, full = 0, almost_empty = 1, data_out = 0, overflow = underflow = 0.
2. **Fill, drain and wrap (width=8, depth=8):**
   - Write 0x01..0x08. Require count 1..8; almost_full at count 6; full after the 8th write.
   - Read 8 words. Require data_out sequence 0x01..0x08 and empty at the end.
   - Repeat with 0x11..0x18 to exercise pointer wrap.
3. **Overflow:** write a 9th word 0xAA while full with rd = 0.
   - Require overflow = 1; count stays 8.
   - Draining yields 0x01..0x08; 0xAA never appears.
4. **Simultaneous operations:**
   - Full with wr && rd for 4 cycles: count stays 8; FIFO order is preserved.
   - Empty with wr && rd: count = 1; underflow = 1; data_out = written word.
5. **Flush:** with count = 5 and overflow set, assert clr together with wr.
   - Require count = 0, empty = 1, overflow = 0 next cycle; the concurrent write is discarded.
6. **Asynchronous reset mid-burst:** assert reset_n between edges during back-to-back writes. Require immediate count = 0, empty = 1, data_out = 0.
